// File: rtl/counter_cascade.sv
// Multi-digit modulo-M up/down counter with synchronous clear/load, load clamping,
// a registered one-cycle full-range wrap pulse and a combinational all-zero flag.
module counter_cascade #(
  parameter int unsigned M      = 10,
  parameter int unsigned DIGITS = 4,
  localparam int unsigned DW    = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 wrap,
  output logic                 zero
);

  localparam logic [DW-1:0] MAX = DW'(M - 1);

  logic [DW-1:0] r_digit [DIGITS];
  logic          r_wrap;

  logic [DW-1:0] w_next  [DIGITS];
  logic [DW-1:0] w_loadv [DIGITS];
  logic          w_all_max;
  logic          w_all_zero;

  // Ripple enable is a running AND over lower digits, so the whole cascade
  // settles in one cycle and no digit lags its neighbour.
  always_comb begin
    logic          v_run;
    logic [DW-1:0] v_field;
    v_run      = 1'b1;
    w_all_max  = 1'b1;
    w_all_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_next[i] = r_digit[i];
      if (v_run) begin
        if (up) w_next[i] = (r_digit[i] == MAX) ? '0 : r_digit[i] + DW'(1);
        else    w_next[i] = (r_digit[i] == '0) ? MAX : r_digit[i] - DW'(1);
      end
      v_run      = v_run & (up ? (r_digit[i] == MAX) : (r_digit[i] == '0));
      w_all_max  = w_all_max  & (r_digit[i] == MAX);
      w_all_zero = w_all_zero & (r_digit[i] == '0);
      v_field    = load_val[i*DW +: DW];
      w_loadv[i] = (32'(v_field) >= M) ? MAX : v_field;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int unsigned i = 0; i < DIGITS; i++) r_digit[i] <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) r_digit[i] <= w_loadv[i];
      r_wrap <= 1'b0;
    end else if (en) begin
      for (int unsigned i = 0; i < DIGITS; i++) r_digit[i] <= w_next[i];
      r_wrap <= up ? w_all_max : w_all_zero;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DIGITS; i++) count[i*DW +: DW] = r_digit[i];
  end

  assign wrap = r_wrap;
  assign zero = w_all_zero;

endmodule

// File: tb/tb_counter_cascade.sv
// Directed bench for counter_cascade: decimal 2- and 4-digit instances and a
// radix-6 3-digit instance sharing one set of control inputs.
module tb_counter_cascade;

  logic        clk = 1'b0;
  logic        rst_n, en, up, clr, load;
  logic [7:0]  lv2;
  logic [15:0] lv4;
  logic [8:0]  lv6;
  logic [7:0]  cnt2;
  logic [15:0] cnt4;
  logic [8:0]  cnt6;
  logic        wrap2, wrap4, wrap6, zero2, zero4, zero6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_cascade #(.M(10), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv2), .count(cnt2), .wrap(wrap2), .zero(zero2));

  counter_cascade #(.M(10), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv4), .count(cnt4), .wrap(wrap4), .zero(zero4));

  counter_cascade #(.M(6), .DIGITS(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv6), .count(cnt6), .wrap(wrap6), .zero(zero6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; clr = 1'b0;
    lv2 = 8'h55; lv4 = 16'h1234; lv6 = 9'o123;
    tick(); tick();
    total++; if (cnt2 !== 8'h00) begin $display("FAIL reset_cnt2 got=%h want=00", cnt2); bad++; end
    total++; if (wrap2 !== 1'b0) begin $display("FAIL reset_wrap2 got=%b want=0", wrap2); bad++; end
    total++; if (zero2 !== 1'b1) begin $display("FAIL reset_zero2 got=%b want=1", zero2); bad++; end
    total++; if (zero4 !== 1'b1 || zero6 !== 1'b1) begin $display("FAIL reset_zero46 got=%b%b want=11", zero4, zero6); bad++; end
    rst_n = 1'b1; load = 1'b0;
    tick();
    total++; if (cnt2 !== 8'h01) begin $display("FAIL reset_first_step got=%h want=01", cnt2); bad++; end
    total++; if (zero2 !== 1'b0) begin $display("FAIL reset_zero_after got=%b want=0", zero2); bad++; end
  endtask

  task automatic test_up_wrap();
    en = 1'b0; load = 1'b1; lv2 = 8'h98;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    total++; if (cnt2 !== 8'h99 || wrap2 !== 1'b0) begin $display("FAIL upwrap_99 got=%h/%b want=99/0", cnt2, wrap2); bad++; end
    tick();
    total++; if (cnt2 !== 8'h00 || wrap2 !== 1'b1 || zero2 !== 1'b1) begin $display("FAIL upwrap_00 got=%h/%b/%b want=00/1/1", cnt2, wrap2, zero2); bad++; end
    tick();
    total++; if (cnt2 !== 8'h01 || wrap2 !== 1'b0) begin $display("FAIL upwrap_01 got=%h/%b want=01/0", cnt2, wrap2); bad++; end
  endtask

  task automatic test_down_wrap();
    en = 1'b0; load = 1'b1; lv2 = 8'h10;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    total++; if (cnt2 !== 8'h09 || wrap2 !== 1'b0) begin $display("FAIL borrow_09 got=%h/%b want=09/0", cnt2, wrap2); bad++; end
    en = 1'b0; load = 1'b1; lv2 = 8'h00;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    total++; if (cnt2 !== 8'h99 || wrap2 !== 1'b1) begin $display("FAIL downwrap_99 got=%h/%b want=99/1", cnt2, wrap2); bad++; end
    en = 1'b0;
    tick();
    total++; if (cnt2 !== 8'h99 || wrap2 !== 1'b0) begin $display("FAIL idle_wrap_clear got=%h/%b want=99/0", cnt2, wrap2); bad++; end
  endtask

  task automatic test_load_prio();
    en = 1'b0; load = 1'b1; lv2 = 8'hC5; lv6 = {3'd7, 3'd6, 3'd2};
    tick();
    total++; if (cnt2 !== 8'h95) begin $display("FAIL clamp_dec got=%h want=95", cnt2); bad++; end
    total++; if (cnt6 !== {3'd5, 3'd5, 3'd2}) begin $display("FAIL clamp_r6 got=%o want=552", cnt6); bad++; end
    clr = 1'b1;
    tick();
    total++; if (cnt2 !== 8'h00) begin $display("FAIL clr_over_load got=%h want=00", cnt2); bad++; end
    clr = 1'b0; en = 1'b1; up = 1'b1; lv2 = 8'h42;
    tick();
    total++; if (cnt2 !== 8'h42 || wrap2 !== 1'b0) begin $display("FAIL load_over_en got=%h/%b want=42/0", cnt2, wrap2); bad++; end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_en_gaps();
    logic [7:0] exp_v [5];
    logic       en_v  [5];
    logic       up_v  [5];
    exp_v = '{8'h06, 8'h06, 8'h06, 8'h07, 8'h06};
    en_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    up_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    en = 1'b0; load = 1'b1; lv2 = 8'h05;
    tick();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      en = en_v[k]; up = up_v[k];
      tick();
      total++;
      if (cnt2 !== exp_v[k] || wrap2 !== 1'b0) begin
        $display("FAIL gaps_step%0d got=%h/%b want=%h/0", k, cnt2, wrap2, exp_v[k]); bad++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wide_wrap();
    load = 1'b1; lv4 = 16'h9999;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    total++; if (cnt4 !== 16'h0000 || wrap4 !== 1'b1) begin $display("FAIL wide_up got=%h/%b want=0000/1", cnt4, wrap4); bad++; end
    up = 1'b0;
    tick();
    total++; if (cnt4 !== 16'h9999 || wrap4 !== 1'b1) begin $display("FAIL wide_down got=%h/%b want=9999/1", cnt4, wrap4); bad++; end
    en = 1'b0;
  endtask

  task automatic test_radix6();
    int         pulses;
    int         r;
    logic [8:0] exp_c;
    logic       exp_w;
    pulses = 0;
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 216; n++) begin
      tick();
      r     = n % 216;
      exp_c = {3'(r / 36), 3'((r / 6) % 6), 3'(r % 6)};
      exp_w = (n == 216);
      if (wrap6 === 1'b1) pulses++;
      total++;
      if (cnt6 !== exp_c || wrap6 !== exp_w) begin
        $display("FAIL r6_step%0d got=%o/%b want=%o/%b", n, cnt6, wrap6, exp_c, exp_w); bad++;
      end
    end
    en = 1'b0;
    total++; if (pulses !== 1) begin $display("FAIL r6_pulses got=%0d want=1", pulses); bad++; end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_prio();
    test_en_gaps();
    test_wide_wrap();
    test_radix6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
